// File: rtl/uart_transmitter_if.sv
// Producer-side bundle for uart_transmitter; brk exists only when UART_TX_BREAK_EN is defined.
interface uart_transmitter_if;
  logic [7:0] data;
  logic       send;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
`ifdef UART_TX_BREAK_EN
  logic       brk;

  modport master (output data, send, brk, input ready, tx, busy, frame_done);
  modport slave  (input data, send, brk, output ready, tx, busy, frame_done);
`else
  modport master (output data, send, input ready, tx, busy, frame_done);
  modport slave  (input data, send, output ready, tx, busy, frame_done);
`endif
endinterface

// File: rtl/uart_transmitter.sv
// UART TX (start, 8 data LSB first, even parity, stop), tx valid from the accept edge, one-byte hold gives gapless frames.
// ready = hold empty; UART_TX_BREAK_EN adds brk: break after the current frame, then one mark bit.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  uart_transmitter_if.slave u
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_MARK
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bitcnt, w_bitcnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_par, w_par_nxt;
  logic [7:0]      r_hold, w_hold_nxt;
  logic            r_hold_vld, w_hold_vld_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_bit_end, w_free, w_brk, w_ready, w_accept;

`ifdef UART_TX_BREAK_EN
  assign w_brk   = u.brk;
  assign w_ready = ~r_hold_vld && (r_state != S_BREAK);
`else
  assign w_brk   = 1'b0;
  assign w_ready = ~r_hold_vld;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_accept  = u.send && w_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = (r_state == S_IDLE || w_bit_end) ? '0 : r_baud + CW'(1);
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_done_nxt     = 1'b0;
    w_free         = 1'b0;

    case (r_state)
      S_IDLE:   w_free = 1'b1;
      S_START:  if (w_bit_end) begin
                  w_state_nxt  = S_DATA;
                  w_bitcnt_nxt = 3'd0;
                end
      S_DATA:   if (w_bit_end) begin
                  w_shift_nxt  = r_shift >> 1;
                  w_bitcnt_nxt = r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_bit_end) begin
                  w_done_nxt = 1'b1;
                  w_free     = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
      S_BREAK:  begin
                  w_baud_nxt = '0;
                  if (!w_brk) w_state_nxt = S_MARK;
                end
      S_MARK:   if (w_bit_end) w_free = 1'b1;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase

    // A free slot starts the next frame immediately: held byte first, else a byte arriving this cycle.
    if (w_free) begin
      if (w_brk) begin
`ifdef UART_TX_BREAK_EN
        w_state_nxt = S_BREAK;
`endif
      end else if (r_hold_vld) begin
        w_state_nxt    = S_START;
        w_shift_nxt    = r_hold;
        w_par_nxt      = ^r_hold;
        w_hold_vld_nxt = 1'b0;
      end else if (w_accept) begin
        w_state_nxt = S_START;
        w_shift_nxt = u.data;
        w_par_nxt   = ^u.data;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end

    if (w_accept && !(w_free && !w_brk && !r_hold_vld)) begin
      w_hold_nxt     = u.data;
      w_hold_vld_nxt = 1'b1;
    end

    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  w_tx_nxt = 1'b0;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_hold     <= 8'd0;
      r_hold_vld <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign u.ready      = w_ready;
  assign u.tx         = r_tx;
  assign u.busy       = r_busy;
  assign u.frame_done = r_done;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: CLKS_PER_BIT=1 and 4 instances, frame-level reference model and a behavioural receiver.
module tb_uart_transmitter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cur_send;
  logic [7:0] cur_data;
  logic       cur_brk;
  int         sel;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] stream[$];

  always #5 clk = ~clk;

  uart_transmitter_if if1 ();
  uart_transmitter_if if4 ();

  assign if1.send = cur_send && (sel == 0);
  assign if4.send = cur_send && (sel != 0);
  assign if1.data = cur_data;
  assign if4.data = cur_data;
`ifdef UART_TX_BREAK_EN
  assign if1.brk = cur_brk;
  assign if4.brk = 1'b0;
`endif

  uart_transmitter #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .u(if1));
  uart_transmitter #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .u(if4));

  logic o_tx, o_busy, o_done, o_ready;
  assign o_tx    = (sel != 0) ? if4.tx         : if1.tx;
  assign o_busy  = (sel != 0) ? if4.busy       : if1.busy;
  assign o_done  = (sel != 0) ? if4.frame_done : if1.frame_done;
  assign o_ready = (sel != 0) ? if4.ready      : if1.ready;

  // Behavioural receiver on the CLKS_PER_BIT=1 line: entries are {error, data}.
  logic [10:0] rx_sh;
  int          rx_cnt = 0;
  logic [8:0]  rx_q[$];
  always @(negedge clk) begin
    if (rx_cnt == 0) begin
      if (rst_n === 1'b1 && if1.tx === 1'b0) begin
        rx_sh[0] = 1'b0;
        rx_cnt   = 1;
      end
    end else begin
      rx_sh[rx_cnt] = if1.tx;
      rx_cnt++;
      if (rx_cnt == 11) begin
        rx_q.push_back({(rx_sh[9] !== ^rx_sh[8:1]) || (rx_sh[10] !== 1'b1), rx_sh[8:1]});
        rx_cnt = 0;
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    logic [10:0] f;
    f = {1'b1, ^b, b, 1'b0};
    return f[i];
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Saturating producer: sends each queued byte as soon as ready, so frames must be contiguous.
  task automatic run_stream(input int s, input string tag);
    int cpb, n, total, sent, flen;
    logic etx;
    cpb = (s != 0) ? 4 : 1;
    n = stream.size();
    flen = 11 * cpb;
    total = flen * n;
    sent = 0;
    sel = s;
    #1;
    for (int c = -1; c < total + 2 * cpb + 2; c++) begin
      if (c >= 0) begin
        etx = (c < total) ? exp_bit(stream[c / flen], (c % flen) / cpb) : 1'b1;
        chk({tag, "_tx"}, 9'(o_tx), 9'(etx));
        chk({tag, "_busy"}, 9'(o_busy), 9'(c < total));
        chk({tag, "_done"}, 9'(o_done), 9'(c > 0 && c <= total && (c % flen) == 0));
        chk({tag, "_ready"}, 9'(o_ready),
            9'(!(c >= 1 && c < flen * (n - 1) && (c % flen) != 0)));
      end
      if (sent < n && o_ready) begin
        cur_send = 1'b1;
        cur_data = stream[sent];
        sent++;
      end else begin
        cur_send = 1'b0;
        cur_data = 8'($urandom);
      end
      @(negedge clk);
    end
    cur_send = 1'b0;
  endtask

  initial begin
    logic saw_low, saw_done;
    logic [8:0] rv;
    rst_n = 1'b0; cur_send = 1'b0; cur_data = 8'h00; cur_brk = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_tx", 9'(o_tx), 9'd1);
      chk("rst_busy", 9'(o_busy), 9'd0);
      chk("rst_done", 9'(o_done), 9'd0);
      chk("rst_ready", 9'(o_ready), 9'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    stream = '{8'hA5};        run_stream(0, "a5");
    stream = '{8'h01, 8'h03}; run_stream(0, "b2b");
    stream = '{8'hFF};        run_stream(1, "cpb4_ff");
    stream.delete();
    repeat (5) stream.push_back(8'($urandom));
    run_stream(0, "rnd1");
    stream.delete();
    repeat (3) stream.push_back(8'($urandom));
    run_stream(1, "rnd4");

    // Reset during data bit 3 of 0x5A while 0x77 waits in hold.
    sel = 0;
    cur_send = 1'b1; cur_data = 8'h5A;
    @(negedge clk);
    cur_data = 8'h77;
    @(negedge clk);
    cur_send = 1'b0; cur_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("mid_bit3", 9'(o_tx), 9'(exp_bit(8'h5A, 4)));
    chk("mid_ready", 9'(o_ready), 9'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", 9'(o_tx), 9'd1);
    chk("abort_busy", 9'(o_busy), 9'd0);
    chk("abort_ready", 9'(o_ready), 9'd1);
    chk("abort_done", 9'(o_done), 9'd0);
    rst_n = 1'b1;
    saw_low = 1'b0; saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_tx !== 1'b1) saw_low = 1'b1;
      if (o_done !== 1'b0) saw_done = 1'b1;
    end
    chk("abort_no_tx", 9'(saw_low), 9'd0);
    chk("abort_no_done", 9'(saw_done), 9'd0);

    rx_q.delete();
    stream = '{8'h3C, 8'hC3};
    run_stream(0, "loop");
    chk("loop_cnt", 9'(rx_q.size()), 9'd2);
    rv = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
    chk("loop_b0", rv, {1'b0, 8'h3C});
    rv = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
    chk("loop_b1", rv, {1'b0, 8'hC3});

`ifdef UART_TX_BREAK_EN
    // brk seen on edges 6..25: break from the end of frame 0x10, one mark bit, then held 0x22.
    sel = 0;
    for (int c = -1; c < 45; c++) begin
      if (c >= 0) begin
        logic etx;
        if (c <= 10) etx = exp_bit(8'h10, c);
        else if (c <= 25) etx = 1'b0;
        else if (c == 26) etx = 1'b1;
        else if (c <= 37) etx = exp_bit(8'h22, c - 27);
        else etx = 1'b1;
        chk("brk_tx", 9'(o_tx), 9'(etx));
        chk("brk_busy", 9'(o_busy), 9'(c <= 37));
        chk("brk_done", 9'(o_done), 9'(c == 11 || c == 38));
        chk("brk_ready", 9'(o_ready), 9'(c == 0 || c >= 27));
      end
      cur_send = (c == -1 || c == 0);
      cur_data = (c == -1) ? 8'h10 : 8'h22;
      cur_brk  = (c >= 5 && c <= 24);
      @(negedge clk);
    end
    cur_send = 1'b0;
    cur_brk  = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
